irrigation_zone_scheduler: RTL

Parametrised multi-zone successor to the single-line irrigation controller. It owns the tank-level counter, the fill/water/clean state machine and a round-robin arbiter that grants one of `ZONES` irrigation zones at a time, each zone in sprinkler or dripper mode. It also runs the fertilise/clean sequence and raises a sticky alarm. It sits between the input conditioning (switches, debounced pulses, `tick` from the clock divider) and the matrix display decoders.

---
 rtl/irrigation_zone_scheduler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/irrigation_zone_scheduler.sv
// Multi-zone irrigation scheduler: tank level, fill/water/clean sequencing,
// round-robin zone grant and the fertilise/clean sequence with a sticky alarm.
module irrigation_zone_scheduler #(
   parameter int ZONES        = 4,
   parameter int LEVEL_W      = 3,
   parameter int DRIP_DIV     = 4,
   parameter int SPRINKLE_DIV = 2,
   parameter int FERT_TICKS   = 8,
   parameter int CLEAN_TICKS  = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               tick,
   input  logic [ZONES-1:0]   zone_req,
   input  logic [ZONES-1:0]   zone_mode,
   input  logic               fertilise_push,
   output logic [LEVEL_W-1:0] water_level,
   output logic               filling,
   output logic [ZONES-1:0]   zone_active,
   output logic               active_mode,
   output logic               fertilising,
   output logic               cleaning,
   output logic               alarm
);

   localparam int PTR_W   = $clog2(ZONES);
   localparam int MAX_DIV = (DRIP_DIV > SPRINKLE_DIV) ? DRIP_DIV : SPRINKLE_DIV;
   localparam int DCNT_W  = $clog2(MAX_DIV + 1);
   localparam int FCNT_W  = $clog2(FERT_TICKS + 1);
   localparam int CCNT_W  = $clog2(CLEAN_TICKS + 1);
   localparam logic [LEVEL_W-1:0] LEVEL_FULL = '1;
   localparam logic [LEVEL_W-1:0] LEVEL_LOW  = LEVEL_W'(2 ** (LEVEL_W - 1));

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WATER = 2'd2,
      ST_CLEAN = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LEVEL_W-1:0]  level_q, level_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    grant_idx_q, grant_idx_d;
   logic [ZONES-1:0]    zone_active_q, zone_active_d;
   logic                mode_q, mode_d;
   logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic                fert_q, fert_d;
   logic [FCNT_W-1:0]   fert_cnt_q, fert_cnt_d;
   logic [CCNT_W-1:0]   clean_cnt_q, clean_cnt_d;
   logic                alarm_q, alarm_d;
   logic                filling_q, filling_d;
   logic                cleaning_q, cleaning_d;

   // Requests rotated so that offset 0 is the zone under the round-robin pointer.
   logic [ZONES-1:0]    rot_req;
   logic [PTR_W-1:0]    rot_idx [ZONES];

   for (genvar gi = 0; gi < ZONES; gi++) begin : g_rot
      logic [PTR_W:0] idx_sum;
      assign idx_sum     = {1'b0, ptr_q} + (PTR_W+1)'(gi);
      assign rot_idx[gi] = (idx_sum >= (PTR_W+1)'(ZONES))
                           ? PTR_W'(idx_sum - (PTR_W+1)'(ZONES))
                           : idx_sum[PTR_W-1:0];
      assign rot_req[gi] = zone_req[rot_idx[gi]];
   end

   logic             pick_valid;
   logic [PTR_W-1:0] pick_idx;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int k = ZONES - 1; k >= 0; k--) begin
         if (rot_req[k]) begin
            pick_valid = 1'b1;
            pick_idx   = rot_idx[k];
         end
      end
   end

   logic [DCNT_W-1:0] drain_inc;
   logic [DCNT_W-1:0] div_sel;
   logic [FCNT_W-1:0] fert_inc;
   logic [CCNT_W-1:0] clean_inc;
   logic [PTR_W-1:0]  next_ptr;
   logic              fert_expire;

   assign drain_inc   = drain_cnt_q + DCNT_W'(1);
   assign div_sel     = mode_q ? DCNT_W'(SPRINKLE_DIV) : DCNT_W'(DRIP_DIV);
   assign fert_inc    = fert_cnt_q + FCNT_W'(1);
   assign clean_inc   = clean_cnt_q + CCNT_W'(1);
   assign next_ptr    = (grant_idx_q == PTR_W'(ZONES - 1)) ? '0 : grant_idx_q + PTR_W'(1);
   assign fert_expire = fert_q && tick && (fert_inc == FCNT_W'(FERT_TICKS));

   always_comb begin
      logic release_zone;
      release_zone  = 1'b0;
      state_d       = state_q;
      level_d       = level_q;
      ptr_d         = ptr_q;
      grant_idx_d   = grant_idx_q;
      zone_active_d = zone_active_q;
      mode_d        = mode_q;
      drain_cnt_d   = drain_cnt_q;
      fert_d        = fert_q;
      fert_cnt_d    = fert_cnt_q;
      clean_cnt_d   = clean_cnt_q;
      alarm_d       = alarm_q;

      case (state_q)
         ST_FILL: begin
            if (tick && (level_q != LEVEL_FULL)) level_d = level_q + LEVEL_W'(1);
            if (level_d == LEVEL_FULL) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (level_q <= LEVEL_W'(1)) begin
               state_d = ST_FILL;
            end else if (pick_valid) begin
               state_d       = ST_WATER;
               grant_idx_d   = pick_idx;
               zone_active_d = ZONES'(1) << pick_idx;
               mode_d        = zone_mode[pick_idx];
               drain_cnt_d   = '0;
            end
         end
         ST_WATER: begin
            // Leaving the zone (drop or fertilise expiry) takes priority over any drain.
            if (!zone_req[grant_idx_q] || fert_expire) begin
               release_zone = 1'b1;
               ptr_d        = next_ptr;
               state_d      = fert_q ? ST_CLEAN : ST_IDLE;
               fert_d       = 1'b0;
               fert_cnt_d   = '0;
               clean_cnt_d  = '0;
            end else begin
               if (tick) begin
                  if (drain_inc == div_sel) begin
                     drain_cnt_d = '0;
                     if (level_q != '0) level_d = level_q - LEVEL_W'(1);
                  end else begin
                     drain_cnt_d = drain_inc;
                  end
                  if (fert_q) fert_cnt_d = fert_inc;
               end
               if (fert_q) begin
                  if (level_d == '0) begin
                     alarm_d      = 1'b1;
                     fert_d       = 1'b0;
                     fert_cnt_d   = '0;
                     state_d      = ST_FILL;
                     release_zone = 1'b1;
                  end
               end else if (level_d <= LEVEL_W'(1)) begin
                  state_d      = ST_FILL;
                  release_zone = 1'b1;
               end else if (fertilise_push && mode_q && (level_q >= LEVEL_LOW)) begin
                  fert_d     = 1'b1;
                  fert_cnt_d = '0;
               end
            end
         end
         ST_CLEAN: begin
            if (tick) begin
               if (clean_inc == CCNT_W'(CLEAN_TICKS)) begin
                  clean_cnt_d = '0;
                  state_d     = ST_IDLE;
               end else begin
                  clean_cnt_d = clean_inc;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase

      if (release_zone) begin
         zone_active_d = '0;
         mode_d        = 1'b0;
      end
   end

   assign filling_d  = (state_d == ST_FILL);
   assign cleaning_d = (state_d == ST_CLEAN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_FILL;
         level_q       <= '0;
         ptr_q         <= '0;
         grant_idx_q   <= '0;
         zone_active_q <= '0;
         mode_q        <= 1'b0;
         drain_cnt_q   <= '0;
         fert_q        <= 1'b0;
         fert_cnt_q    <= '0;
         clean_cnt_q   <= '0;
         alarm_q       <= 1'b0;
         filling_q     <= 1'b1;
         cleaning_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         level_q       <= level_d;
         ptr_q         <= ptr_d;
         grant_idx_q   <= grant_idx_d;
         zone_active_q <= zone_active_d;
         mode_q        <= mode_d;
         drain_cnt_q   <= drain_cnt_d;
         fert_q        <= fert_d;
         fert_cnt_q    <= fert_cnt_d;
         clean_cnt_q   <= clean_cnt_d;
         alarm_q       <= alarm_d;
         filling_q     <= filling_d;
         cleaning_q    <= cleaning_d;
      end
   end

   assign water_level = level_q;
   assign filling     = filling_q;
   assign zone_active = zone_active_q;
   assign active_mode = mode_q;
   assign fertilising = fert_q;
   assign cleaning    = cleaning_q;
   assign alarm       = alarm_q;

endmodule
